// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state encoding, frame/data widths and command codes.
`timescale 1ns/1ps
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  localparam logic [CNT_W-1:0] FRAME_LEN = 4'd10;
  localparam logic [CNT_W-1:0] DATA_LEN  = 4'd8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus one-clk rise/fall pulses
// derived from the synchronized value.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave front end: receives 10-bit {cmd, payload} frames for the RAM and
// shifts read data back on miso during RD_DATA frames.
`timescale 1ns/1ps
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [FRAME_W-1:0]   rx_data,
  output logic                 rx_valid,
  input  logic [DATA_W-1:0]    tx_data,
  input  logic                 tx_valid
);

  logic sclk_rise, sclk_fall;
  logic sample_edge, shift_edge;

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ss_s, mosi_s;

  state_t             state;
  logic               rd_addr_seen;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-2:0] rx_sr;
  logic [DATA_W-1:0]  tx_sr;
  logic [CNT_W-1:0]   tx_cnt;
  logic               rd_wait;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (CPOL)
  ) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // ss_n and mosi use the same depth as sclk so all three stay aligned in time.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign ss_s        = ss_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
  assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;

  // rx_sr holds the first nine bits; the tenth goes straight into rx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_addr_seen <= 1'b0;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      tx_cnt       <= '0;
      rd_wait      <= 1'b0;
      miso         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_s) begin
        state   <= IDLE;
        bit_cnt <= '0;
        rx_sr   <= '0;
        tx_sr   <= '0;
        tx_cnt  <= '0;
        rd_wait <= 1'b0;
        miso    <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;

          CHK_CMD: begin
            if (sample_edge) begin
              rx_sr   <= {rx_sr[FRAME_W-3:0], mosi_s};
              bit_cnt <= 4'd1;
              if (!mosi_s)          state <= WRITE;
              else if (rd_addr_seen) state <= READ_DATA;
              else                   state <= READ_ADD;
            end
          end

          WRITE, READ_ADD, READ_DATA: begin
            if (sample_edge && bit_cnt != FRAME_LEN) begin
              rx_sr   <= {rx_sr[FRAME_W-3:0], mosi_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == FRAME_LEN - 4'd1) begin
                rx_data  <= {rx_sr, mosi_s};
                rx_valid <= 1'b1;
                if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                if (state == READ_DATA) rd_addr_seen <= 1'b0;
              end
            end
            // Read data is only accepted once, on the first tx_valid after the strobe.
            if (state == READ_DATA) begin
              if (rx_valid) rd_wait <= 1'b1;
              if (rd_wait && tx_valid) begin
                tx_sr   <= tx_data;
                tx_cnt  <= DATA_LEN;
                rd_wait <= 1'b0;
              end else if (shift_edge) begin
                if (tx_cnt != '0) begin
                  miso   <= tx_sr[DATA_W-1];
                  tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                  tx_cnt <= tx_cnt - 4'd1;
                end else begin
                  miso <= 1'b0;
                end
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: a mode-0 and a mode-3 instance share one master driver;
// received frames are scored against a queue of expected words.
`timescale 1ns/1ps
module tb_spi_slave_rx;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk0, sclk3, ss_n, mosi, tx_valid;
  logic [7:0] tx_data;
  logic       miso0, miso3, rx_valid0, rx_valid3;
  logic [9:0] rx_data0, rx_data3;

  int         n_vec = 0;
  int         n_err = 0;
  int         rxv3_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  always #5 clk = ~clk;

  spi_slave_rx #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .ss_n(ss_n), .mosi(mosi), .miso(miso0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  spi_slave_rx #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst(rst), .sclk(sclk3), .ss_n(ss_n), .mosi(mosi), .miso(miso3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rx_strobe: got rx_valid with rx_data 0x%0h, expected no strobe", rx_data0);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_data0 !== mon_exp) begin
          n_err++;
          $display("FAIL rx_data: got 0x%0h, expected 0x%0h", rx_data0, mon_exp);
        end
      end
    end
    if (rx_valid3) rxv3_cnt++;
  end

  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  task automatic begin_frame();
    ss_n = 1'b0;
    half();
  endtask

  task automatic send_bits(input logic [9:0] v, input int n);
    for (int i = 9; i > 9 - n; i--) begin
      sclk0 = 1'b0; sclk3 = 1'b0; mosi = v[i];
      half();
      sclk0 = 1'b1; sclk3 = 1'b1;
      half();
    end
  endtask

  task automatic end_frame();
    sclk0 = 1'b0; sclk3 = 1'b1;
    half();
    ss_n = 1'b1;
    half(); half();
    mosi = 1'b0;
  endtask

  typedef struct {
    logic [9:0] frame;
    logic [9:0] exp_rx;
    state_t     exp_state;
    logic       exp_seen;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] rd_byte;
    int         c3;

    rst = 1'b1; sclk0 = 1'b0; sclk3 = 1'b1; ss_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;

    vecs[0] = '{10'h0A5, 10'h0A5, WRITE,     1'b0};
    vecs[1] = '{10'h13C, 10'h13C, WRITE,     1'b0};
    vecs[2] = '{10'h000, 10'h000, WRITE,     1'b0};
    vecs[3] = '{10'h1FF, 10'h1FF, WRITE,     1'b0};
    vecs[4] = '{10'h207, 10'h207, READ_ADD,  1'b1};
    vecs[5] = '{10'h0F0, 10'h0F0, WRITE,     1'b1};
    vecs[6] = '{10'h2AA, 10'h2AA, READ_DATA, 1'b0};
    vecs[7] = '{10'h3AA, 10'h3AA, READ_ADD,  1'b1};
    vecs[8] = '{10'h355, 10'h355, READ_DATA, 1'b0};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_valid", 32'(rx_valid0), 32'h0);
    check("reset_rx_data", 32'(rx_data0), 32'h0);
    check("reset_miso", 32'(miso0), 32'h0);
    check("reset_state", 32'(dut0.state), 32'(IDLE));
    check("reset_seen", 32'(dut0.rd_addr_seen), 32'h0);

    for (int v = 0; v < 9; v++) begin
      begin_frame();
      exp_q.push_back(vecs[v].exp_rx);
      send_bits(vecs[v].frame, 10);
      half();
      check($sformatf("vec%0d_state", v), 32'(dut0.state), 32'(vecs[v].exp_state));
      check($sformatf("vec%0d_miso", v), 32'(miso0), 32'h0);
      end_frame();
      check($sformatf("vec%0d_strobe", v), 32'(exp_q.size()), 32'h0);
      check($sformatf("vec%0d_idle", v), 32'(dut0.state), 32'(IDLE));
      check($sformatf("vec%0d_seen", v), 32'(dut0.rd_addr_seen), 32'(vecs[v].exp_seen));
    end

    // Mode-3 instance: WR_DATA frame 0x155.
    c3 = rxv3_cnt;
    begin_frame();
    exp_q.push_back(10'h155);
    send_bits(10'h155, 10);
    end_frame();
    check("mode3_rx_data", 32'(rx_data3), 32'h155);
    check("mode3_strobes", 32'(rxv3_cnt - c3), 32'h1);
    check("mode3_q_drain", 32'(exp_q.size()), 32'h0);

    // RD_ADDR then RD_DATA returning 0xC3; a later tx_valid must be ignored.
    begin_frame();
    exp_q.push_back(10'h207);
    send_bits(10'h207, 10);
    end_frame();
    check("rd_addr_seen_set", 32'(dut0.rd_addr_seen), 32'h1);
    begin_frame();
    exp_q.push_back(10'h3C5);
    send_bits(10'h3C5, 10);
    repeat (2) @(negedge clk);
    check("rd_data_strobe", 32'(exp_q.size()), 32'h0);
    check("rd_addr_seen_clr", 32'(dut0.rd_addr_seen), 32'h0);
    tx_data = 8'hC3; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h5A;
    repeat (2) @(negedge clk);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    rd_byte = 8'hC3;
    for (int b = 7; b >= 0; b--) begin
      sclk0 = 1'b0; sclk3 = 1'b0;
      half();
      sclk0 = 1'b1; sclk3 = 1'b1;
      check($sformatf("miso0_bit%0d", b), 32'(miso0), 32'(rd_byte[b]));
      check($sformatf("miso3_bit%0d", b), 32'(miso3), 32'(rd_byte[b]));
      half();
    end
    sclk0 = 1'b0; sclk3 = 1'b0;
    half();
    check("miso0_after_bit0", 32'(miso0), 32'h0);
    end_frame();
    check("rd_seen_final", 32'(dut0.rd_addr_seen), 32'h0);

    // Abort after 6 bits, then a clean RD_ADDR frame 0x2FF.
    begin_frame();
    send_bits(10'h2FF, 6);
    end_frame();
    check("abort6_idle", 32'(dut0.state), 32'(IDLE));
    check("abort6_cnt", 32'(dut0.bit_cnt), 32'h0);
    begin_frame();
    exp_q.push_back(10'h2FF);
    send_bits(10'h2FF, 10);
    end_frame();
    check("after_abort_strobe", 32'(exp_q.size()), 32'h0);
    check("after_abort_seen", 32'(dut0.rd_addr_seen), 32'h1);

    // ss_n rises together with the 10th sampling edge: no strobe.
    begin_frame();
    send_bits(10'h0A5, 9);
    sclk0 = 1'b0; sclk3 = 1'b0; mosi = 1'b1;
    half();
    sclk0 = 1'b1; sclk3 = 1'b1; ss_n = 1'b1;
    half();
    sclk0 = 1'b0;
    half(); half();
    check("same_clk_abort_idle", 32'(dut0.state), 32'(IDLE));
    check("same_clk_abort_seen", 32'(dut0.rd_addr_seen), 32'h1);

    // Reset at bit 4 of a READ_DATA frame.
    begin_frame();
    send_bits(10'h3C0, 4);
    check("pre_rst_state", 32'(dut0.state), 32'(READ_DATA));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_state", 32'(dut0.state), 32'(IDLE));
    check("rst_seen", 32'(dut0.rd_addr_seen), 32'h0);
    check("rst_miso", 32'(miso0), 32'h0);
    check("rst_rx_data", 32'(rx_data0), 32'h0);
    send_bits(10'h3C0 << 4, 6);
    end_frame();
    check("rst_no_strobe", 32'(exp_q.size()), 32'h0);
    check("rst_seen_final", 32'(dut0.rd_addr_seen), 32'h0);
    check("rst_miso_final", 32'(miso0), 32'h0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
